// File: rtl/lsu_data_mem.sv
// Load/store data memory: byte/half/word/double access, sign/zero extension,
// valid/ready request handshake with fixed read latency and error reporting.
module lsu_data_mem #(
   parameter int XLEN         = 32,
   parameter int DEPTH_WORDS  = 1024,
   parameter int ADDR_WIDTH   = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [XLEN-1:0]       req_wdata,
   output logic                  resp_valid,
   output logic [XLEN-1:0]       resp_rdata,
   output logic [1:0]            resp_err
);

   localparam int NB    = XLEN / 8;
   localparam int OFF_W = $clog2(NB);
   localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;

   logic [XLEN-1:0] mem [DEPTH_WORDS];

   logic                  accept;
   logic                  illegal;
   logic                  misal;
   logic                  oor;
   logic [1:0]            err_n;
   logic [2:0]            amask;
   logic [7:0]            size_mask;
   logic [ADDR_WIDTH-1:0] word_addr;
   logic [IDX_W-1:0]      idx;
   logic [OFF_W-1:0]      lane;
   logic [NB-1:0]         be;
   logic [XLEN-1:0]       wdata_sh;
   logic [XLEN-1:0]       rd_word;
   logic [XLEN-1:0]       shifted;
   logic [XLEN-1:0]       load_data;

   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == RESP);
   assign accept     = req_valid && req_ready;

   assign word_addr = req_addr >> OFF_W;
   assign idx       = word_addr[IDX_W-1:0];
   assign lane      = req_addr[OFF_W-1:0];
   assign oor       = word_addr >= ADDR_WIDTH'(DEPTH_WORDS);

   always_comb begin
      size_mask = 8'h01;
      amask     = 3'b000;
      case (req_funct3[1:0])
         2'b00: begin size_mask = 8'h01; amask = 3'b000; end
         2'b01: begin size_mask = 8'h03; amask = 3'b001; end
         2'b10: begin size_mask = 8'h0f; amask = 3'b011; end
         default: begin size_mask = 8'hff; amask = 3'b111; end
      endcase
   end

   assign misal = |(req_addr[2:0] & amask);

   always_comb begin
      illegal = 1'b0;
      if (req_write)
         illegal = req_funct3[2] ||
                   (req_funct3[1:0] == 2'b11 && XLEN == 32);
      else
         illegal = (req_funct3 == 3'b111) ||
                   (XLEN == 32 && (req_funct3 == 3'b011 ||
                                   req_funct3 == 3'b110));
   end

   // illegal size outranks misalignment, which outranks range
   always_comb begin
      err_n = 2'b00;
      priority case (1'b1)
         illegal: err_n = 2'b11;
         misal:   err_n = 2'b01;
         oor:     err_n = 2'b10;
         default: err_n = 2'b00;
      endcase
   end

   assign be       = NB'(size_mask) << lane;
   assign wdata_sh = req_wdata << {lane, 3'b000};
   assign rd_word  = mem[idx];
   assign shifted  = rd_word >> {lane, 3'b000};

   always_comb begin
      load_data = shifted;
      case (req_funct3)
         3'b000:  load_data = XLEN'($signed(shifted[7:0]));
         3'b001:  load_data = XLEN'($signed(shifted[15:0]));
         3'b010:  load_data = XLEN'($signed(shifted[31:0]));
         3'b100:  load_data = XLEN'(shifted[7:0]);
         3'b101:  load_data = XLEN'(shifted[15:0]);
         3'b110:  load_data = XLEN'(shifted[31:0]);
         default: load_data = shifted;
      endcase
   end

   always_ff @(posedge clk) begin
      if (accept && req_write && err_n == 2'b00) begin
         for (int b = 0; b < NB; b++) begin
            if (be[b]) mem[idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         resp_rdata <= '0;
         resp_err   <= 2'b00;
      end else if (accept) begin
         resp_err   <= err_n;
         resp_rdata <= (!req_write && err_n == 2'b00) ? load_data : '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (READ_LATENCY == 1) begin
                  state_n = RESP;
               end else begin
                  state_n = WAIT;
                  cnt_n   = CNT_W'(READ_LATENCY - 1);
               end
            end
         end
         WAIT: begin
            if (cnt == CNT_W'(1)) begin
               state_n = RESP;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_lsu_data_mem.sv
// Bench for lsu_data_mem: three configurations checked against a
// byte-addressed reference memory kept in an associative array.
module tb_lsu_data_mem;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [2:0]  vld = 3'b000;
   logic        w = 1'b0;
   logic [2:0]  f3 = 3'b000;
   logic [31:0] addr = 32'h0;
   logic [63:0] wd = 64'h0;

   logic        rdy0, rdy1, rdy2;
   logic        rv0, rv1, rv2;
   logic [31:0] rd0, rd2;
   logic [63:0] rd1;
   logic [1:0]  er0, er1, er2;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] mm [int];

   always #5 clk = ~clk;

   lsu_data_mem #(.XLEN(32), .DEPTH_WORDS(1024), .ADDR_WIDTH(32),
                  .READ_LATENCY(1)) d0 (
      .clk(clk), .reset(reset), .req_valid(vld[0]), .req_ready(rdy0),
      .req_write(w), .req_funct3(f3), .req_addr(addr),
      .req_wdata(wd[31:0]), .resp_valid(rv0), .resp_rdata(rd0),
      .resp_err(er0));

   lsu_data_mem #(.XLEN(64), .DEPTH_WORDS(64), .ADDR_WIDTH(32),
                  .READ_LATENCY(4)) d1 (
      .clk(clk), .reset(reset), .req_valid(vld[1]), .req_ready(rdy1),
      .req_write(w), .req_funct3(f3), .req_addr(addr),
      .req_wdata(wd), .resp_valid(rv1), .resp_rdata(rd1),
      .resp_err(er1));

   lsu_data_mem #(.XLEN(32), .DEPTH_WORDS(16), .ADDR_WIDTH(32),
                  .READ_LATENCY(3)) d2 (
      .clk(clk), .reset(reset), .req_valid(vld[2]), .req_ready(rdy2),
      .req_write(w), .req_funct3(f3), .req_addr(addr),
      .req_wdata(wd[31:0]), .resp_valid(rv2), .resp_rdata(rd2),
      .resp_err(er2));

   function automatic int xlen_of(input int s);
      return (s == 1) ? 64 : 32;
   endfunction

   function automatic int depth_of(input int s);
      return (s == 0) ? 1024 : (s == 1) ? 64 : 16;
   endfunction

   function automatic int lat_of(input int s);
      return (s == 0) ? 1 : (s == 1) ? 4 : 3;
   endfunction

   function automatic logic get_rdy(input int s);
      return (s == 0) ? rdy0 : (s == 1) ? rdy1 : rdy2;
   endfunction

   function automatic logic get_rv(input int s);
      return (s == 0) ? rv0 : (s == 1) ? rv1 : rv2;
   endfunction

   function automatic logic [63:0] get_rd(input int s);
      return (s == 0) ? {32'h0, rd0} : (s == 1) ? rd1 : {32'h0, rd2};
   endfunction

   function automatic logic [1:0] get_er(input int s);
      return (s == 0) ? er0 : (s == 1) ? er1 : er2;
   endfunction

   function automatic int key(input int s, input int a);
      return s * 32'h0010_0000 + a;
   endfunction

   // Reference: byte-level memory plus the access rules in plain arithmetic
   function automatic void model(input int s, input bit wr,
                                 input bit [2:0] f, input int a,
                                 input logic [63:0] d,
                                 output logic [63:0] rd,
                                 output logic [1:0] er);
      int xl;
      int sz;
      bit ill;
      logic [63:0] v;
      xl = xlen_of(s);
      sz = 1 << f[1:0];
      if (wr) ill = f[2] || (f[1:0] == 2'd3 && xl == 32);
      else ill = (f == 3'd7) || (xl == 32 && (f == 3'd3 || f == 3'd6));
      rd = 64'h0;
      if (ill) er = 2'b11;
      else if (a % sz != 0) er = 2'b01;
      else if (a / (xl / 8) >= depth_of(s)) er = 2'b10;
      else er = 2'b00;
      if (er == 2'b00) begin
         if (wr) begin
            for (int i = 0; i < sz; i++) mm[key(s, a + i)] = d[i*8 +: 8];
         end else begin
            v = 64'h0;
            for (int i = 0; i < sz; i++)
               v = v | (64'(mm[key(s, a + i)]) << (8 * i));
            if (!f[2] && sz < 8 && v[sz*8-1])
               v = v | ~((64'd1 << (sz * 8)) - 64'd1);
            if (xl == 32) v[63:32] = 32'h0;
            rd = v;
         end
      end
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one request from a negedge with the block idle; ends on a negedge
   task automatic do_req(input int s, input bit wr, input bit [2:0] f,
                         input int a, input logic [63:0] d,
                         output logic [63:0] ord, output logic [1:0] oer);
      logic [63:0] erd;
      logic [1:0]  eer;
      int lat;
      int npulse;
      int rl;
      rl = lat_of(s);
      model(s, wr, f, a, d, erd, eer);
      w = wr;
      f3 = f;
      addr = a;
      wd = d;
      vld[s] = 1'b1;
      chk("ready_idle", 64'(get_rdy(s)), 64'd1);
      @(posedge clk);
      #1 vld[s] = 1'b0;
      lat = 0;
      npulse = 0;
      ord = 64'h0;
      oer = 2'b00;
      for (int k = 1; k <= rl + 1; k++) begin
         @(negedge clk);
         if (get_rv(s)) begin
            npulse++;
            lat = k;
            ord = get_rd(s);
            oer = get_er(s);
         end
         chk("ready_busy", 64'(get_rdy(s)), 64'(k == rl + 1));
      end
      chk("resp_pulses", 64'(npulse), 64'd1);
      chk("resp_latency", 64'(lat), 64'(rl));
      chk("resp_rdata", ord, erd);
      chk("resp_err", 64'(oer), 64'(eer));
   endtask

   initial begin
      logic [63:0] r;
      logic [63:0] keep;
      logic [1:0]  e;
      int          nresp;

      repeat (2) @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         chk("rst_ready", 64'(get_rdy(s)), 64'd1);
         chk("rst_valid", 64'(get_rv(s)), 64'd0);
         chk("rst_rdata", get_rd(s), 64'd0);
         chk("rst_err", 64'(get_er(s)), 64'd0);
      end
      reset = 1'b0;
      @(negedge clk);

      for (int s = 0; s < 3; s++) begin
         for (int a = 0; a < 64; a += xlen_of(s) / 8) begin
            do_req(s, 1'b1, (s == 1) ? 3'd3 : 3'd2, a,
                   {$urandom, $urandom}, r, e);
         end
      end

      do_req(0, 1'b1, 3'd2, 'h10, 64'h8000_00f1, r, e);
      do_req(0, 1'b0, 3'd0, 'h10, 64'h0, r, e);
      chk("lb_f1", r, 64'hffff_fff1);
      do_req(0, 1'b0, 3'd4, 'h10, 64'h0, r, e);
      chk("lbu_f1", r, 64'h0000_00f1);
      do_req(0, 1'b0, 3'd1, 'h12, 64'h0, r, e);
      chk("lh_8000", r, 64'hffff_8000);
      do_req(0, 1'b0, 3'd5, 'h12, 64'h0, r, e);
      chk("lhu_8000", r, 64'h0000_8000);

      do_req(0, 1'b1, 3'd2, 'h20, 64'h1122_3344, r, e);
      do_req(0, 1'b1, 3'd0, 'h21, 64'haa, r, e);
      do_req(0, 1'b0, 3'd2, 'h20, 64'h0, r, e);
      chk("sb_merge", r, 64'h1122_aa44);
      do_req(0, 1'b1, 3'd1, 'h22, 64'hbeef, r, e);
      do_req(0, 1'b0, 3'd2, 'h20, 64'h0, r, e);
      chk("sh_merge", r, 64'hbeef_aa44);

      do_req(0, 1'b0, 3'd2, 'h02, 64'h0, r, e);
      chk("lw_misal", 64'(e), 64'd1);
      do_req(0, 1'b0, 3'd2, 'h00, 64'h0, keep, e);
      do_req(0, 1'b1, 3'd1, 'h03, 64'hffff, r, e);
      chk("sh_misal", 64'(e), 64'd1);
      do_req(0, 1'b0, 3'd2, 'h00, 64'h0, r, e);
      chk("misal_nowrite", r, keep);
      do_req(0, 1'b0, 3'd2, 'h1000, 64'h0, r, e);
      chk("lw_oor", 64'(e), 64'd2);
      do_req(0, 1'b0, 3'd3, 'h08, 64'h0, r, e);
      chk("ld_x32", 64'(e), 64'd3);
      do_req(0, 1'b0, 3'd3, 'h01, 64'h0, r, e);
      chk("ill_over_misal", 64'(e), 64'd3);
      do_req(0, 1'b0, 3'd6, 'h04, 64'h0, r, e);
      do_req(0, 1'b1, 3'd4, 'h04, 64'h0, r, e);
      chk("st_bit2", 64'(e), 64'd3);

      do_req(0, 1'b1, 3'd2, 'hffc, 64'h5a6b_7c8d, r, e);
      do_req(0, 1'b0, 3'd4, 'hfff, 64'h0, r, e);
      chk("top_byte", r, 64'h5a);
      do_req(0, 1'b0, 3'd2, 'hffc, 64'h0, r, e);
      do_req(0, 1'b1, 3'd0, 'h1000, 64'h1, r, e);
      chk("sb_oor", 64'(e), 64'd2);

      do_req(1, 1'b1, 3'd3, 'h8, 64'h8000_0000_0000_0001, r, e);
      do_req(1, 1'b0, 3'd6, 'hc, 64'h0, r, e);
      chk("lwu64", r, 64'h0000_0000_8000_0000);
      do_req(1, 1'b0, 3'd2, 'hc, 64'h0, r, e);
      chk("lw64", r, 64'hffff_ffff_8000_0000);
      do_req(1, 1'b0, 3'd3, 'h8, 64'h0, r, e);
      chk("ld64", r, 64'h8000_0000_0000_0001);
      do_req(1, 1'b1, 3'd3, 'h1f8, 64'h0123_4567_89ab_cdef, r, e);
      do_req(1, 1'b0, 3'd3, 'h1f8, 64'h0, r, e);
      do_req(1, 1'b0, 3'd3, 'h200, 64'h0, r, e);
      chk("ld_oor64", 64'(e), 64'd2);

      // Request held high: accepts every 5 cycles at latency 4
      w = 1'b0;
      f3 = 3'd3;
      addr = 'h8;
      vld[1] = 1'b1;
      nresp = 0;
      for (int k = 1; k <= 19; k++) begin
         @(negedge clk);
         chk("b2b_ready", 64'(rdy1), 64'(k % 5 == 0 || k > 14));
         chk("b2b_valid", 64'(rv1), 64'(k % 5 == 4 && k < 15));
         if (rv1) begin
            nresp++;
            chk("b2b_rdata", rd1, 64'h8000_0000_0000_0001);
         end
         if (k == 14) vld[1] = 1'b0;
      end
      chk("b2b_count", 64'(nresp), 64'd3);

      for (int i = 0; i < 150; i++) begin
         int s;
         s = i % 3;
         do_req(s, 1'($urandom), 3'($urandom),
                int'($urandom_range(0, (s == 2) ? 79 : 63)),
                {$urandom, $urandom}, r, e);
      end

      // Reset during WAIT of a store: no response, store already committed
      w = 1'b1;
      f3 = 3'd2;
      addr = 'h24;
      wd = 64'hcafe_f00d;
      model(2, 1'b1, 3'd2, 'h24, 64'hcafe_f00d, r, e);
      vld[2] = 1'b1;
      @(posedge clk);
      #1 vld[2] = 1'b0;
      @(negedge clk);
      chk("pre_rst_wait", 64'(rdy2), 64'd0);
      reset = 1'b1;
      #1;
      chk("midrst_ready", 64'(rdy2), 64'd1);
      chk("midrst_valid", 64'(rv2), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      nresp = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (rv2) nresp++;
      end
      chk("midrst_noresp", 64'(nresp), 64'd0);
      chk("midrst_rdata", 64'(rd2), 64'd0);
      do_req(2, 1'b0, 3'd2, 'h24, 64'h0, r, e);
      chk("midrst_kept", r, 64'hcafe_f00d);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lsu_data_mem.md
Name: lsu_data_mem

Overview:
- Parametrised load/store data memory that replaces the word-only, single-cycle-read memory array inside the multicycle datapath.
- Supports byte, halfword, word and (XLEN=64) doubleword access, selected by RISC-V funct3.
- Sign/zero-extends load data and applies per-byte write enables.
- Uses a valid/ready request handshake with configurable read latency, one outstanding request at a time.
- Flags misaligned, out-of-range and illegal-size accesses instead of silently aliasing.

Parameters:
- XLEN, 32: data width; legal values 32 or 64.
- DEPTH_WORDS, 1024: number of XLEN-wide words in the array.
- ADDR_WIDTH, 32: byte-address width.
- READ_LATENCY, 1: cycles from request acceptance to resp_valid; must be ≥1.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 access size/sign.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  XLEN  store data, right-justified.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  XLEN  extended load data; 0 for stores and faults.
- resp_err  out  2  00 ok, 01 misaligned, 10 out of range, 11 illegal funct3.

Behaviour:
Reset and FSM
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=00, latency counter 0.
- Array contents are not reset.
- FSM states are IDLE, WAIT and RESP.
- IDLE: req_ready=1. A request is accepted when req_valid && req_ready at a rising edge.
  - READ_LATENCY==1: go to RESP.
  - Otherwise: load counter with READ_LATENCY-1 and go to WAIT.
- WAIT: req_ready=0. Counter decrements each cycle; when it is 1, go to RESP.
- RESP: resp_valid=1 for exactly one cycle, req_ready=0, then return to IDLE. There is no response backpressure.
- Result: accept edge N gives resp_valid high in cycle N+READ_LATENCY, and the next request can be accepted at edge N+READ_LATENCY+1.
- resp_rdata and resp_err are registered at accept, held stable until the next accept, and only meaningful while resp_valid=1.

Access decode
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; when XLEN=64 also 011 LD and 110 LWU. All other load encodings are illegal.
- Legal stores: 000 SB, 001 SH, 010 SW; when XLEN=64 also 011 SD. funct3 bit2 set on a store is illegal.
- Access size in bytes = 1 << funct3[1:0].
- Misaligned when addr mod size ≠ 0.
- Word index = addr >> log2(XLEN/8). Out of range when word index ≥ DEPTH_WORDS.
- Error priority: illegal > misaligned > out of range.
- Any error: no array write, resp_rdata=0, resp_err set. Latency is still exactly READ_LATENCY.

Data path
- Little-endian byte lanes; lane offset = addr mod (XLEN/8).
- Store: on the accept edge, write only the size bytes starting at the lane, using req_wdata's low bytes. Other bytes are unchanged. resp_rdata=0, resp_err=00.
- Load: array word is read at the accept edge. Selected bytes are shifted down, then sign-extended (LB/LH/LW) or zero-extended (LBU/LHU/LWU) to XLEN.
- A load reads data committed by any earlier accepted store (no hazard, single outstanding).

Boundary and simultaneous events
- req_valid while req_ready=0 is ignored. The requester holds the request until ready; the block does not latch it.
- Reset mid-operation (WAIT/RESP): return to IDLE immediately, no resp_valid pulse. A store committed at accept stays in the array.
- Highest legal address: DEPTH_WORDS*XLEN/8 − size. One byte beyond that gives error 10.

Test Plan:
- XLEN=32, READ_LATENCY=1: SW 0x8000_00F1 @0x10; LB @0x10, LBU @0x10, LH @0x12, LHU @0x12 → 0xFFFF_FFF1, 0x0000_00F1, 0xFFFF_8000, 0x0000_8000, each resp_err=00, resp_valid exactly 1 cycle after accept.
- SB 0xAA @0x21 over word 0x1122_3344 @0x20; LW @0x20 → 0x1122_AA44. Same with SH 0xBEEF @0x22 → 0xBEEF_AA44.
- LW @0x02 → err 01; SH @0x03 → err 01 and the following LW @0x00 shows memory unchanged; LW @0x1000 (DEPTH_WORDS=1024) → err 10; load funct3 011 at XLEN=32 → err 11; misaligned illegal funct3 → err 11 (priority check).
- READ_LATENCY=4: back-to-back req_valid held high → accepts spaced 5 cycles apart, req_ready low for 4 cycles after each accept, resp_valid on the 4th cycle after accept, no extra responses.
- XLEN=64: SD 0x8000_0000_0000_0001 @0x8; LWU @0xC → 0x0000_0000_8000_0000; LW @0xC → 0xFFFF_FFFF_8000_0000; LD @0x8 returns the full value.
- Assert reset in the WAIT state of a READ_LATENCY=3 store → no resp_valid, req_ready=1 after reset; a load of that address returns the stored data.
